phy_tx_sched: RTL and testbench
===============================

Name: phy_tx_sched

Overview:
Parametrised next-generation PHY transmitter: NCH byte channels are multiplexed onto one serial line.
Runs on a single bit-rate clock; symbol slots are derived from an internal bit counter, replacing the separate per-rate clocks of the previous generation.
Adds per-channel valid/ready backpressure, round-robin or fixed-TDM slot scheduling, a qualified link-active state, and automatic COM/IDL symbol insertion.
Sits between the channel sources and the serial link; the receiver's active indication is fed back on in_rx_tx.

Parameters:
NCH, 4, channel count, legal range 1..8.
W, 8, symbol width in bits, must be >= 8.
MODE, 0, scheduling mode: 0 = round-robin over valid channels, 1 = fixed TDM with one slot per channel in turn.
ACT_CNT, 4, number of consecutive symbol boundaries with in_rx_tx = 1 required to raise link_active.
CW, derived as max(1, clog2(NCH)), channel index width.

Ports:
clk32f  in  1  bit-rate clock; the only clock in the block.
reset  in  1  asynchronous, active-low reset (0 = reset).
in_data  in  NCH*W  flattened channel data; channel i occupies bits [i*W +: W].
in_valid  in  NCH  per-channel data valid.
in_ready  out  NCH  one-hot pulse; the channel's word is consumed this cycle.
in_rx_tx  in  1  receiver active indication.
out_b  out  1  serial output, MSB first.
sym_start  out  1  high in the cycle the first bit of a symbol appears on out_b.
link_active  out  1  qualified link state.
tx_ch  out  CW  channel of the symbol currently being sent; 0 for COM/IDL.
tx_is_data  out  1  current symbol carries channel data.

Behaviour:
- Reset values: bit_cnt = W-1, shift register = 0, out_b = 0, sym_start = 0, link_active = 0, in_ready = 0, tx_ch = 0, tx_is_data = 0, act_cnt = 0, rr_last = NCH-1, tdm_slot = 0.
- Boundary: the cycle in which bit_cnt == W-1. On its clock edge bit_cnt goes to 0 and the next symbol is loaded. Otherwise bit_cnt increments and the shift register shifts left by 1.
- out_b is the registered MSB of the shift register. The first symbol's MSB appears on the 1st edge after reset deasserts. Each symbol lasts exactly W cycles.
- sym_start is registered and is high for 1 cycle, aligned with each symbol's MSB.
- Link qualifier, evaluated at each boundary:
  - in_rx_tx = 1: act_cnt saturates at ACT_CNT. link_active is set when act_cnt reaches ACT_CNT, and the new state applies to the same load.
  - in_rx_tx = 0: act_cnt and link_active clear immediately, effective from that load.
- Symbol selection at a boundary:
  - link_active = 0: load COM (0xBC, zero-extended to W). All in_ready stay 0.
  - RR mode: search channels starting at rr_last+1, wrapping modulo NCH. The first channel with in_valid = 1 is chosen; load its data, pulse in_ready for it, and set rr_last to that channel. If no channel is valid, load IDL (0x7C) and leave rr_last unchanged.
  - TDM mode: chosen channel = tdm_slot. If it is valid, load its data and pulse in_ready; otherwise load IDL. tdm_slot increments modulo NCH at every active boundary. It is held at 0 while the link is inactive.
- in_ready is combinational, high only in the boundary cycle and only for the chosen channel. Transfer = valid & ready in that cycle. in_valid is sampled only at boundaries, so a source may withdraw valid between boundaries.
- tx_ch and tx_is_data are registered with the load and held for the whole symbol.
- in_rx_tx falling mid-symbol: the current symbol completes unaltered; the next boundary loads COM.
- Reset mid-symbol: all state returns to reset values at once and the partially sent symbol is lost. Data not yet handshaken stays owned by the source.
- NCH = 1: RR and TDM behave identically; tx_ch is always 0.

Decomposition:
- Shared header phy_defs.vh: COM_SYM = 8'hBC, IDL_SYM = 8'h7C, MODE_RR = 0, MODE_TDM = 1.
- Sub-module phy_tx_rr_arb: combinational rotating-priority picker. Inputs: in_valid, rr_last, MODE, tdm_slot. Outputs: grant index and grant-valid.
- The serializer, bit counter and link qualifier live in the top.

Test Plan:
1. Reset then in_rx_tx = 0 for 40 cycles -> out_b repeats 10111100 every 8 cycles; in_ready never asserted; link_active = 0.
2. in_rx_tx = 1 from cycle 0, ACT_CNT = 4 -> 4 COM symbols, then link_active = 1 from the 5th symbol; with no valid input, IDL 01111100 is sent.
3. RR mode, all 4 channels valid with data 0x11, 0x22, 0x33, 0x44 held -> symbols 0x11, 0x22, 0x33, 0x44, 0x11; in_ready pulses ch0, ch1, ch2, ch3, ch0, one per boundary.
4. RR mode, only ch2 valid after ch0 was served -> ch2 sent next; rr_last = 2; next search starts at ch3.
5. TDM mode, only ch1 valid (0xA5) -> symbol sequence IDL, 0xA5, IDL, IDL, IDL, 0xA5; tx_is_data high only in the 0xA5 slots.
6. in_rx_tx dropped in the middle of a 0x22 symbol -> 0x22 completes; next symbol is COM; link_active = 0; reasserting requires 4 boundaries. Reset asserted mid-symbol -> out_b = 0 immediately.

Source files
------------

// File: rtl/phy_tx_sched_pkg.sv
// Shared constants and helpers for the PHY transmit scheduler.
//   COM_SYM / IDL_SYM : 8-bit comma and idle symbols, zero-extended to W by users.
//   MODE_RR / MODE_TDM: scheduling-mode encodings for the MODE parameter.
//   clog2_min1()      : ceil(log2(n)), but never less than 1 (for index/counter widths).
package phy_tx_sched_pkg;

  localparam logic [7:0]  COM_SYM  = 8'hBC;
  localparam logic [7:0]  IDL_SYM  = 8'h7C;
  localparam int unsigned MODE_RR  = 0;
  localparam int unsigned MODE_TDM = 1;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phy_tx_sched_if.sv
// Channel-source bundle for the PHY transmit scheduler.
//   in_data  : NCH*W flattened words, channel i at [i*W +: W]
//   in_valid : per-channel word valid (driven by the sources)
//   in_ready : one-hot consume pulse (driven by the scheduler)
// Modports: master = channel sources, slave = scheduler.
interface phy_tx_sched_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 8
);
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/phy_tx_rr_arb.sv
// Combinational channel picker for the PHY transmit scheduler.
//   in_valid  : per-channel valid
//   rr_last   : last granted channel (round-robin mode)
//   tdm_slot  : current slot (TDM mode)
//   gnt       : chosen channel index
//   gnt_valid : chosen channel has a word to send
// Round-robin searches from rr_last+1 upward, wrapping modulo NCH.
// TDM simply offers the current slot's channel.
module phy_tx_rr_arb
  import phy_tx_sched_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned MODE = MODE_RR,
  localparam int unsigned CW  = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] in_valid,
  input  logic [CW-1:0]  rr_last,
  input  logic [CW-1:0]  tdm_slot,
  output logic [CW-1:0]  gnt,
  output logic           gnt_valid
);

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    if (MODE == MODE_TDM) begin
      gnt       = tdm_slot;
      gnt_valid = in_valid[tdm_slot];
    end else begin
      // Walk from the farthest candidate back to the nearest so the nearest valid one wins.
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
        int idx;
        idx = (int'(rr_last) + 1 + i) % int'(NCH);
        if (in_valid[idx]) begin
          gnt       = CW'(idx);
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phy_tx_sched.sv
// PHY transmitter: multiplexes NCH byte channels onto one serial line, MSB first.
//   clk32f      : bit-rate clock
//   reset       : asynchronous active-low reset
//   ch          : channel sources (data/valid in, one-hot ready out)
//   in_rx_tx    : receiver-active indication, sampled at symbol boundaries
//   out_b       : serial output
//   sym_start   : high while the first bit of a symbol is on out_b
//   link_active : qualified link state
//   tx_ch       : channel of the symbol being sent (0 for COM/IDL)
//   tx_is_data  : symbol being sent carries channel data
module phy_tx_sched
  import phy_tx_sched_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned MODE    = MODE_RR,
  parameter int unsigned ACT_CNT = 4,
  localparam int unsigned CW     = clog2_min1(NCH)
) (
  input  logic          clk32f,
  input  logic          reset,
  phy_tx_sched_if.slave ch,
  input  logic          in_rx_tx,
  output logic          out_b,
  output logic          sym_start,
  output logic          link_active,
  output logic [CW-1:0] tx_ch,
  output logic          tx_is_data
);

  localparam int unsigned BW  = clog2_min1(W);
  localparam int unsigned ACW = clog2_min1(ACT_CNT + 1);

  logic [BW-1:0]  r_bit_cnt;
  logic [W-1:0]   r_shift;
  logic           r_out, r_sym_start, r_link, r_is_data;
  logic [CW-1:0]  r_tx_ch, r_rr_last, r_tdm_slot;
  logic [ACW-1:0] r_act_cnt;

  logic           w_boundary, w_link_d, w_gnt_valid, w_take;
  logic [ACW-1:0] w_act_d;
  logic [CW-1:0]  w_gnt;
  logic [W-1:0]   w_sym;
  logic [NCH-1:0] w_ready;

  assign w_boundary = (r_bit_cnt == BW'(W - 1));

  // Link qualifier. The link rises at the boundary after the counter has already
  // reached ACT_CNT, so ACT_CNT COM symbols go out with the receiver active first.
  always_comb begin
    w_act_d  = r_act_cnt;
    w_link_d = r_link;
    if (w_boundary) begin
      if (in_rx_tx) begin
        w_link_d = r_link | (r_act_cnt == ACW'(ACT_CNT));
        if (r_act_cnt != ACW'(ACT_CNT)) w_act_d = r_act_cnt + 1'b1;
      end else begin
        w_act_d  = '0;
        w_link_d = 1'b0;
      end
    end
  end

  phy_tx_rr_arb #(
    .NCH  (NCH),
    .MODE (MODE)
  ) u_arb (
    .in_valid  (ch.in_valid),
    .rr_last   (r_rr_last),
    .tdm_slot  (r_tdm_slot),
    .gnt       (w_gnt),
    .gnt_valid (w_gnt_valid)
  );

  // Next-symbol selection uses the link state being written at this same load.
  always_comb begin
    w_take  = w_boundary & w_link_d & w_gnt_valid;
    w_sym   = W'(COM_SYM);
    w_ready = '0;
    if (w_link_d) w_sym = w_gnt_valid ? ch.in_data[int'(w_gnt) * W +: W] : W'(IDL_SYM);
    if (w_take) w_ready[w_gnt] = 1'b1;
  end

  assign ch.in_ready = w_ready;

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      r_bit_cnt   <= BW'(W - 1);
      r_shift     <= '0;
      r_out       <= 1'b0;
      r_sym_start <= 1'b0;
      r_link      <= 1'b0;
      r_is_data   <= 1'b0;
      r_tx_ch     <= '0;
      r_act_cnt   <= '0;
      r_rr_last   <= CW'(NCH - 1);
      r_tdm_slot  <= '0;
    end else if (w_boundary) begin
      r_bit_cnt   <= '0;
      r_shift     <= w_sym;
      r_out       <= w_sym[W-1];
      r_sym_start <= 1'b1;
      r_link      <= w_link_d;
      r_is_data   <= w_take;
      r_tx_ch     <= w_take ? w_gnt : '0;
      r_act_cnt   <= w_act_d;
      if (w_take && MODE == MODE_RR) r_rr_last <= w_gnt;
      // TDM slot only advances on active boundaries and parks at 0 otherwise.
      if (!w_link_d) r_tdm_slot <= '0;
      else r_tdm_slot <= (r_tdm_slot == CW'(NCH - 1)) ? '0 : r_tdm_slot + 1'b1;
    end else begin
      r_bit_cnt   <= r_bit_cnt + 1'b1;
      r_shift     <= r_shift << 1;
      r_out       <= r_shift[W-2];
      r_sym_start <= 1'b0;
    end
  end

  assign out_b       = r_out;
  assign sym_start   = r_sym_start;
  assign link_active = r_link;
  assign tx_ch       = r_tx_ch;
  assign tx_is_data  = r_is_data;

endmodule

// File: tb/tb_phy_tx_sched.sv
// Self-checking bench for phy_tx_sched: one round-robin and one TDM instance
// (NCH=4, W=8, ACT_CNT=4) driven from tables of per-symbol vectors.
module tb_phy_tx_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 8;

  logic clk32f   = 1'b0;
  logic reset    = 1'b0;
  logic in_rx_tx = 1'b0;

  always #5 clk32f = ~clk32f;

  phy_tx_sched_if #(.NCH(NCH), .W(W)) if_rr ();
  phy_tx_sched_if #(.NCH(NCH), .W(W)) if_tdm ();

  logic       out_b0, sym0, link0, isd0;
  logic       out_b1, sym1, link1, isd1;
  logic [1:0] ch0, ch1;

  phy_tx_sched #(.NCH(NCH), .W(W), .MODE(0), .ACT_CNT(4)) u_rr (
    .clk32f      (clk32f),
    .reset       (reset),
    .ch          (if_rr),
    .in_rx_tx    (in_rx_tx),
    .out_b       (out_b0),
    .sym_start   (sym0),
    .link_active (link0),
    .tx_ch       (ch0),
    .tx_is_data  (isd0)
  );

  phy_tx_sched #(.NCH(NCH), .W(W), .MODE(1), .ACT_CNT(4)) u_tdm (
    .clk32f      (clk32f),
    .reset       (reset),
    .ch          (if_tdm),
    .in_rx_tx    (in_rx_tx),
    .out_b       (out_b1),
    .sym_start   (sym1),
    .link_active (link1),
    .tx_ch       (ch1),
    .tx_is_data  (isd1)
  );

  typedef struct packed {
    logic        m;      // 0 = round-robin instance, 1 = TDM instance
    logic        rx;
    logic        drop;   // drop in_rx_tx partway through this symbol
    logic [3:0]  valid;
    logic [31:0] data;
    logic [7:0]  sym;
    logic [3:0]  rdy;
    logic [1:0]  ch;
    logic        isd;
    logic        link;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] D4 = 32'h44332211;

  function automatic vec_t mk(input logic m, input logic rx, input logic drop,
                              input logic [3:0] valid, input logic [31:0] data,
                              input logic [7:0] sym, input logic [3:0] rdy,
                              input logic [1:0] chn, input logic isd, input logic link);
    vec_t v;
    v.m = m; v.rx = rx; v.drop = drop; v.valid = valid; v.data = data;
    v.sym = sym; v.rdy = rdy; v.ch = chn; v.isd = isd; v.link = link;
    return v;
  endfunction

  function automatic logic ob(input logic m);
    return m ? out_b1 : out_b0;
  endfunction
  function automatic logic ss(input logic m);
    return m ? sym1 : sym0;
  endfunction
  function automatic logic lk(input logic m);
    return m ? link1 : link0;
  endfunction
  function automatic logic id(input logic m);
    return m ? isd1 : isd0;
  endfunction
  function automatic logic [1:0] tc(input logic m);
    return m ? ch1 : ch0;
  endfunction
  function automatic logic [3:0] rd(input logic m);
    return m ? if_tdm.in_ready : if_rr.in_ready;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive only the targeted instance; the other sees no valid words.
  task automatic drive(input logic m, input logic [3:0] valid, input logic [31:0] data);
    if_rr.in_valid  = m ? 4'h0 : valid;
    if_rr.in_data   = m ? 32'h0 : data;
    if_tdm.in_valid = m ? valid : 4'h0;
    if_tdm.in_data  = m ? data : 32'h0;
  endtask

  // Entered in a boundary cycle (just after a falling edge); leaves in the next one.
  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] s;
    s = '0;
    in_rx_tx = v.rx;
    drive(v.m, v.valid, v.data);
    #1;
    chk({tag, " in_ready"}, 32'(rd(v.m)), 32'(v.rdy));
    for (int b = 0; b < 8; b++) begin
      @(negedge clk32f);
      s = {s[6:0], ob(v.m)};
      if (b == 0) begin
        chk({tag, " sym_start"}, 32'(ss(v.m)), 32'd1);
        chk({tag, " tx_ch"}, 32'(tc(v.m)), 32'(v.ch));
        chk({tag, " tx_is_data"}, 32'(id(v.m)), 32'(v.isd));
        chk({tag, " link_active"}, 32'(lk(v.m)), 32'(v.link));
      end
      if (b == 2) begin
        chk({tag, " mid sym_start"}, 32'(ss(v.m)), 32'd0);
        chk({tag, " mid in_ready"}, 32'(rd(v.m)), 32'd0);
      end
      if (b == 3 && v.drop) in_rx_tx = 1'b0;
      if (b == 7) chk({tag, " end link_active"}, 32'(lk(v.m)), 32'(v.link));
    end
    chk({tag, " symbol"}, 32'(s), 32'(v.sym));
  endtask

  initial begin
    drive(1'b0, 4'h0, 32'h0);

    // Link down: COM only.
    for (int i = 0; i < 5; i++) tbl_a.push_back(mk(0, 0, 0, 4'h0, 0, 8'hBC, 0, 0, 0, 0));
    // Qualification: 4 COM, then IDL with no valid input.
    for (int i = 0; i < 4; i++) tbl_a.push_back(mk(0, 1, 0, 4'h0, 0, 8'hBC, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 0, 4'h0, 0, 8'h7C, 0, 0, 0, 1));
    // Round-robin over four valid channels.
    tbl_a.push_back(mk(0, 1, 0, 4'hF, D4, 8'h11, 4'h1, 0, 1, 1));
    tbl_a.push_back(mk(0, 1, 0, 4'hF, D4, 8'h22, 4'h2, 1, 1, 1));
    tbl_a.push_back(mk(0, 1, 0, 4'hF, D4, 8'h33, 4'h4, 2, 1, 1));
    tbl_a.push_back(mk(0, 1, 0, 4'hF, D4, 8'h44, 4'h8, 3, 1, 1));
    tbl_a.push_back(mk(0, 1, 0, 4'hF, D4, 8'h11, 4'h1, 0, 1, 1));
    // Only ch2 valid after ch0; search then resumes at ch3.
    tbl_a.push_back(mk(0, 1, 0, 4'h4, 32'h00550000, 8'h55, 4'h4, 2, 1, 1));
    tbl_a.push_back(mk(0, 1, 0, 4'hF, D4, 8'h44, 4'h8, 3, 1, 1));
    // Nothing valid: IDL, pointer kept, so ch0 comes next.
    tbl_a.push_back(mk(0, 1, 0, 4'h0, D4, 8'h7C, 4'h0, 0, 0, 1));
    tbl_a.push_back(mk(0, 1, 0, 4'hF, D4, 8'h11, 4'h1, 0, 1, 1));
    // Receiver drops mid 0x22: symbol completes, then COM.
    tbl_a.push_back(mk(0, 1, 1, 4'hF, D4, 8'h22, 4'h2, 1, 1, 1));
    tbl_a.push_back(mk(0, 0, 0, 4'hF, D4, 8'hBC, 4'h0, 0, 0, 0));
    // Requalification with valid data waiting: 4 COM, then ch2.
    for (int i = 0; i < 4; i++) tbl_a.push_back(mk(0, 1, 0, 4'hF, D4, 8'hBC, 0, 0, 0, 0));
    tbl_a.push_back(mk(0, 1, 0, 4'hF, D4, 8'h33, 4'h4, 2, 1, 1));

    // TDM with only ch1 valid.
    for (int i = 0; i < 4; i++) tbl_b.push_back(mk(1, 1, 0, 4'h2, 32'h0000A500, 8'hBC, 0, 0, 0, 0));
    tbl_b.push_back(mk(1, 1, 0, 4'h2, 32'h0000A500, 8'h7C, 4'h0, 0, 0, 1));
    tbl_b.push_back(mk(1, 1, 0, 4'h2, 32'h0000A500, 8'hA5, 4'h2, 1, 1, 1));
    tbl_b.push_back(mk(1, 1, 0, 4'h2, 32'h0000A500, 8'h7C, 4'h0, 0, 0, 1));
    tbl_b.push_back(mk(1, 1, 0, 4'h2, 32'h0000A500, 8'h7C, 4'h0, 0, 0, 1));
    tbl_b.push_back(mk(1, 1, 0, 4'h2, 32'h0000A500, 8'h7C, 4'h0, 0, 0, 1));
    tbl_b.push_back(mk(1, 1, 0, 4'h2, 32'h0000A500, 8'hA5, 4'h2, 1, 1, 1));

    // Reset state on both instances.
    repeat (3) @(negedge clk32f);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst%0d out_b", m), 32'(ob(m[0])), 32'd0);
      chk($sformatf("rst%0d sym_start", m), 32'(ss(m[0])), 32'd0);
      chk($sformatf("rst%0d link_active", m), 32'(lk(m[0])), 32'd0);
      chk($sformatf("rst%0d tx_ch", m), 32'(tc(m[0])), 32'd0);
      chk($sformatf("rst%0d tx_is_data", m), 32'(id(m[0])), 32'd0);
      chk($sformatf("rst%0d in_ready", m), 32'(rd(m[0])), 32'd0);
    end
    reset = 1'b1;

    foreach (tbl_a[i]) run_vec(tbl_a[i], $sformatf("rr%0d", i));

    // Reset in the middle of 0x44 (01000100) while out_b is high.
    in_rx_tx = 1'b1;
    drive(1'b0, 4'hF, D4);
    #1;
    chk("mid-reset grant", 32'(rd(1'b0)), 32'h8);
    repeat (2) @(negedge clk32f);
    chk("mid-reset bit before", 32'(out_b0), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid-reset out_b", 32'(out_b0), 32'd0);
    chk("mid-reset link_active", 32'(link0), 32'd0);
    chk("mid-reset tx_is_data", 32'(isd0), 32'd0);
    chk("mid-reset in_ready", 32'(rd(1'b0)), 32'd0);
    repeat (2) @(negedge clk32f);
    reset = 1'b1;

    foreach (tbl_b[i]) run_vec(tbl_b[i], $sformatf("tdm%0d", i));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
